line_burst_adapter: RTL and testbench
=====================================

# line_burst_adapter

Responder for the cache's 256-bit physical-memory port. It accepts one cacheline read or write from the cache datapath/controller and turns it into a four-beat, 64-bit burst to physical memory. On a read it assembles the four returned beats into a line; on a write it serializes the cache's line into four beats. It sits between the L1 cache (pmem side) and the memory model or arbiter.

## Interface
Parameters:
- `LINE_W`, 256: cacheline width in bits.
- `BEAT_W`, 64: memory burst beat width in bits.
- `BEATS`, LINE_W/BEAT_W = 4: beats per line; counter width is $clog2(BEATS) = 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: synchronous active-high reset.
- `line_address_i` in 32: cache byte address; bits [4:0] are ignored.
- `line_read_i` in 1: cache requests a line read; held until `line_resp_o`.
- `line_write_i` in 1: cache requests a line write; held until `line_resp_o`.
- `line_wdata_i` in LINE_W: line to write; sampled at request capture.
- `line_rdata_o` out LINE_W: assembled read line.
- `line_resp_o` out 1: one-cycle completion pulse.
- `mem_address_o` out 32: line-aligned burst address {addr[31:5], 5'b0}.
- `mem_read_o` out 1: burst read request.
- `mem_write_o` out 1: burst write request.
- `mem_wdata_o` out BEAT_W: current write beat.
- `mem_rdata_i` in BEAT_W: current read beat, valid when `mem_resp_i` is high.
- `mem_resp_i` in 1: memory accepted/returned one beat this cycle.

## Operation
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE: if `line_write_i`, go to WR_BURST. Otherwise, if `line_read_i`, go to RD_BURST. Write wins when both are high.
- On capture:
  - Latch `mem_address_o` = {line_address_i[31:5], 5'b0}.
  - On a write, latch `line_wdata_i` into an internal line buffer.
  - Clear the beat counter to 0.
- RD_BURST:
  - `mem_read_o` = 1.
  - Each cycle with `mem_resp_i` = 1: store `mem_rdata_i` into buffer[64*cnt +: 64], then cnt++.
  - Beat 0 is bits [63:0], little-endian beat order.
- WR_BURST:
  - `mem_write_o` = 1.
  - `mem_wdata_o` = buffer[64*cnt +: 64].
  - Each cycle with `mem_resp_i` = 1, cnt++.
- `mem_resp_i` low in a burst state is a stall. Hold the counter, data, address and request.
- When `mem_resp_i` = 1 and cnt = 3, go to DONE. The counter wraps to 0.
- DONE: `line_resp_o` = 1 for exactly one cycle, then go to IDLE. `line_read_i`/`line_write_i` are ignored in DONE.
- `line_rdata_o` = read buffer, held until the next read burst writes beat 0. A write does not disturb it, because the read and write buffers are separate or the read buffer is kept.
- `mem_resp_i` while in IDLE or DONE is ignored.

## Timing
- Reset values: `line_rdata_o` 0, `line_resp_o` 0, `mem_address_o` 0, `mem_read_o` 0, `mem_write_o` 0, `mem_wdata_o` 0. State is IDLE and cnt is 0.
- Request seen in IDLE at cycle T: `mem_read_o`/`mem_write_o` are high from T+1.
- With no stalls:
  - Beats complete at T+1..T+4.
  - `line_resp_o` is high at T+5.
  - IDLE again at T+6.
- Minimum latency is request-to-resp 5 cycles, plus one cycle per stall cycle.
- `mem_read_o`/`mem_write_o` drop in the DONE cycle, so the memory sees them low the cycle after the 4th `mem_resp_i`.
- `line_rdata_o` holds the complete line in the `line_resp_o` cycle.
- The cache must deassert its request in the cycle after `line_resp_o`. If the request is still high in IDLE, a new burst starts; this is legal back-to-back operation.
- `rst` asserted mid-burst: on the next edge all outputs take their reset values and the FSM goes to IDLE; the partial line is discarded. No `line_resp_o` is issued for the aborted request.
- `mem_address_o` and `mem_wdata_o` are stable for the whole burst except the beat advance.

## Test plan
- Read, no stalls:
  - Stimulus: `line_read_i` at addr 0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with `mem_resp_i` on 4 consecutive cycles.
  - Required: `mem_address_o` = 0x0000_1220; `line_rdata_o` = {0x44..44, 0x33..33, 0x22..22, 0x11..11}; `line_resp_o` one cycle, 5 cycles after the request.
- Write with stalls:
  - Stimulus: `line_write_i`, `line_wdata_i` = {D3, D2, D1, D0}; `mem_resp_i` pattern 1,0,0,1,1,0,1.
  - Required: `mem_wdata_o` sequence D0, D1, D1, D1, D2, D3, D3; `line_resp_o` the cycle after the last 1.
- Both requests high:
  - Stimulus: `line_read_i` and `line_write_i` both = 1 in IDLE.
  - Required: WR_BURST entered, `mem_read_o` never asserted.
- Reset mid-burst:
  - Stimulus: `rst` after the 2nd read beat.
  - Required: next cycle all outputs 0, no `line_resp_o`; a new read then completes correctly.
- Back-to-back:
  - Stimulus: read held through DONE into IDLE.
  - Required: a second burst starts, `mem_read_o` rises 1 cycle after IDLE; the earlier `line_rdata_o` is held until the new beat 0 arrives.
- Spurious `mem_resp_i` in IDLE:
  - Required: no state change, counter stays 0.

Source files
------------

// File: rtl/line_burst_adapter_if.sv
// Bundle of the cache-side line port and the memory-side beat port of the adapter.
// Latency: none; this is wiring only.
// Backpressure: memory stalls by holding mem_resp_i low; the cache holds its request until line_resp_o.
// Ports (names seen from the adapter):
//   line_address_i/line_read_i/line_write_i/line_wdata_i -> request from cache
//   line_rdata_o/line_resp_o                             -> completion to cache
//   mem_address_o/mem_read_o/mem_write_o/mem_wdata_o     -> burst to memory
//   mem_rdata_i/mem_resp_i                               -> beat return from memory
interface line_burst_adapter_if #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
);
  logic [31:0]       line_address_i;
  logic              line_read_i;
  logic              line_write_i;
  logic [LINE_W-1:0] line_wdata_i;
  logic [LINE_W-1:0] line_rdata_o;
  logic              line_resp_o;
  logic [31:0]       mem_address_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic [BEAT_W-1:0] mem_wdata_o;
  logic [BEAT_W-1:0] mem_rdata_i;
  logic              mem_resp_i;

  // Environment side: cache controller plus memory model.
  modport master (
    output line_address_i, line_read_i, line_write_i, line_wdata_i,
    input  line_rdata_o, line_resp_o,
    input  mem_address_o, mem_read_o, mem_write_o, mem_wdata_o,
    output mem_rdata_i, mem_resp_i
  );

  // Adapter side.
  modport slave (
    input  line_address_i, line_read_i, line_write_i, line_wdata_i,
    output line_rdata_o, line_resp_o,
    output mem_address_o, mem_read_o, mem_write_o, mem_wdata_o,
    input  mem_rdata_i, mem_resp_i
  );
endinterface

// File: rtl/line_burst_adapter.sv
// Turns one cacheline read/write into a BEATS-beat burst; assembles read beats, serializes write beats.
// Latency: request in IDLE at T -> beats from T+1 -> line_resp_o at T+5 with no stalls.
// Backpressure: mem_resp_i low in a burst stalls; counter, address, data and request all hold.
// Ports: clk, rst (synchronous, active-high), bus (line_burst_adapter_if.slave) carrying
//        the cache line port and the memory beat port.
module line_burst_adapter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  line_burst_adapter_if.slave  bus
);
  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-within-line offset so the burst starts on a line boundary.
  localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                    state_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [31:0]                   addr_q;
  // Separate read and write buffers so a write never disturbs the last read line.
  logic [BEATS-1:0][BEAT_W-1:0]  rd_buf_q;
  logic [BEATS-1:0][BEAT_W-1:0]  wr_buf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      rd_buf_q <= '0;
      wr_buf_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Write takes priority when both requests are up.
          if (bus.line_write_i) begin
            state_q  <= S_WR;
            addr_q   <= bus.line_address_i & LINE_MASK;
            wr_buf_q <= bus.line_wdata_i;
            cnt_q    <= '0;
          end else if (bus.line_read_i) begin
            state_q <= S_RD;
            addr_q  <= bus.line_address_i & LINE_MASK;
            cnt_q   <= '0;
          end
        end
        S_RD: begin
          if (bus.mem_resp_i) begin
            rd_buf_q[cnt_q] <= bus.mem_rdata_i;
            cnt_q           <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_DONE;
            end
          end
        end
        S_WR: begin
          if (bus.mem_resp_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Requests are still high here by protocol; ignore them for one cycle.
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.line_rdata_o  = rd_buf_q;
  assign bus.line_resp_o   = (state_q == S_DONE);
  assign bus.mem_address_o = addr_q;
  assign bus.mem_read_o    = (state_q == S_RD);
  assign bus.mem_write_o   = (state_q == S_WR);
  // Driven to zero outside a write burst so the bus is quiet when idle.
  assign bus.mem_wdata_o   = (state_q == S_WR) ? wr_buf_q[cnt_q] : '0;
endmodule

// File: tb/tb_line_burst_adapter.sv
// Directed bench for line_burst_adapter: table-driven read/write cycles plus hand sequences.
module tb_line_burst_adapter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_burst_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

  line_burst_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Inputs are applied and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic resp, input logic [63:0] rdata);
    bus.line_read_i  = rd;
    bus.line_write_i = wr;
    bus.mem_resp_i   = resp;
    bus.mem_rdata_i  = rdata;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic        resp;
    logic [63:0] rdata;
    logic [31:0] addr;
    logic        e_rd;
    logic        e_wr;
    logic        e_resp;
    logic [63:0] e_wdata;
    logic [31:0] e_addr;
  } vec_t;

  localparam logic [63:0] R0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] R1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] R2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] R3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'h0000_0000_DEAD_0000;
  localparam logic [63:0] D1 = 64'h1111_0000_BEEF_0001;
  localparam logic [63:0] D2 = 64'h2222_0000_CAFE_0002;
  localparam logic [63:0] D3 = 64'h3333_0000_F00D_0003;
  localparam logic [31:0] A1 = 32'h0000_1234;
  localparam logic [31:0] A2 = 32'h0000_ABCD;

  vec_t tv[17];
  logic [255:0] rline;
  logic [255:0] gline;

  initial begin
    // Read with no stalls (rows 0-6), then write with stall pattern 1,0,0,1,1,0,1 (rows 7-16).
    tv[0]  = '{1'b1, 1'b0, 1'b0, 64'h0, A1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0};
    tv[1]  = '{1'b1, 1'b0, 1'b1, R0,    A1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[2]  = '{1'b1, 1'b0, 1'b1, R1,    A1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[3]  = '{1'b1, 1'b0, 1'b1, R2,    A1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[4]  = '{1'b1, 1'b0, 1'b1, R3,    A1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 64'h0, A1, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_1220};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 64'h0, A1, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[7]  = '{1'b0, 1'b1, 1'b0, 64'h0, A2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_1220};
    tv[8]  = '{1'b0, 1'b1, 1'b1, 64'h0, A2, 1'b0, 1'b1, 1'b0, D0,    32'h0000_ABC0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 64'h0, A2, 1'b0, 1'b1, 1'b0, D1,    32'h0000_ABC0};
    tv[10] = '{1'b0, 1'b1, 1'b0, 64'h0, A2, 1'b0, 1'b1, 1'b0, D1,    32'h0000_ABC0};
    tv[11] = '{1'b0, 1'b1, 1'b1, 64'h0, A2, 1'b0, 1'b1, 1'b0, D1,    32'h0000_ABC0};
    tv[12] = '{1'b0, 1'b1, 1'b1, 64'h0, A2, 1'b0, 1'b1, 1'b0, D2,    32'h0000_ABC0};
    tv[13] = '{1'b0, 1'b1, 1'b0, 64'h0, A2, 1'b0, 1'b1, 1'b0, D3,    32'h0000_ABC0};
    tv[14] = '{1'b0, 1'b1, 1'b1, 64'h0, A2, 1'b0, 1'b1, 1'b0, D3,    32'h0000_ABC0};
    tv[15] = '{1'b0, 1'b1, 1'b0, 64'h0, A2, 1'b0, 1'b0, 1'b1, 64'h0, 32'h0000_ABC0};
    tv[16] = '{1'b0, 1'b0, 1'b0, 64'h0, A2, 1'b0, 1'b0, 1'b0, 64'h0, 32'h0000_ABC0};
    rline = {R3, R2, R1, R0};

    rst = 1'b1;
    bus.line_address_i = 32'h0;
    bus.line_wdata_i   = {D3, D2, D1, D0};
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    tick();
    chk("reset line_rdata", bus.line_rdata_o, 256'h0);
    chk("reset line_resp", 256'(bus.line_resp_o), 256'h0);
    chk("reset mem_address", 256'(bus.mem_address_o), 256'h0);
    chk("reset mem_read", 256'(bus.mem_read_o), 256'h0);
    chk("reset mem_write", 256'(bus.mem_write_o), 256'h0);
    chk("reset mem_wdata", 256'(bus.mem_wdata_o), 256'h0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      drive(tv[i].rd, tv[i].wr, tv[i].resp, tv[i].rdata);
      bus.line_address_i = tv[i].addr;
      chk($sformatf("row%0d mem_read", i), 256'(bus.mem_read_o), 256'(tv[i].e_rd));
      chk($sformatf("row%0d mem_write", i), 256'(bus.mem_write_o), 256'(tv[i].e_wr));
      chk($sformatf("row%0d line_resp", i), 256'(bus.line_resp_o), 256'(tv[i].e_resp));
      chk($sformatf("row%0d mem_wdata", i), 256'(bus.mem_wdata_o), 256'(tv[i].e_wdata));
      chk($sformatf("row%0d mem_address", i), 256'(bus.mem_address_o), 256'(tv[i].e_addr));
      if (i == 5) chk("read line at resp", bus.line_rdata_o, rline);
      tick();
    end
    chk("read line kept after write", bus.line_rdata_o, rline);

    // Both requests high: write must win, mem_read never rises.
    bus.line_address_i = 32'h0000_2000;
    bus.line_wdata_i   = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    drive(1'b1, 1'b1, 1'b0, 64'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 1'b1, 64'hBAD);
      chk($sformatf("both beat%0d mem_read", k), 256'(bus.mem_read_o), 256'h0);
      chk($sformatf("both beat%0d mem_write", k), 256'(bus.mem_write_o), 256'h1);
      chk($sformatf("both beat%0d mem_wdata", k), 256'(bus.mem_wdata_o), 256'(64'hE0 + 64'(k)));
      tick();
    end
    chk("both done resp", 256'(bus.line_resp_o), 256'h1);
    chk("both done mem_read", 256'(bus.mem_read_o), 256'h0);
    chk("both read line kept", bus.line_rdata_o, rline);
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();

    // Spurious mem_resp_i in IDLE.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD);
      chk($sformatf("spur%0d mem_read", k), 256'(bus.mem_read_o), 256'h0);
      chk($sformatf("spur%0d line_resp", k), 256'(bus.line_resp_o), 256'h0);
      tick();
    end
    chk("spur read line kept", bus.line_rdata_o, rline);

    // Reset after the second read beat.
    bus.line_address_i = 32'h0000_0040;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'hAAAA);
    tick();
    drive(1'b1, 1'b0, 1'b1, 64'hBBBB);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    rst = 1'b0;
    chk("rst mid line_rdata", bus.line_rdata_o, 256'h0);
    chk("rst mid mem_read", 256'(bus.mem_read_o), 256'h0);
    chk("rst mid mem_address", 256'(bus.mem_address_o), 256'h0);
    chk("rst mid line_resp", 256'(bus.line_resp_o), 256'h0);
    tick();
    chk("rst mid no late resp", 256'(bus.line_resp_o), 256'h0);
    bus.line_address_i = 32'h0000_009F;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    chk("post-rst mem_address", 256'(bus.mem_address_o), 256'h80);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 64'hF0 + 64'(k));
      chk($sformatf("post-rst beat%0d mem_read", k), 256'(bus.mem_read_o), 256'h1);
      tick();
    end
    chk("post-rst resp", 256'(bus.line_resp_o), 256'h1);
    chk("post-rst line", bus.line_rdata_o, {64'hF3, 64'hF2, 64'hF1, 64'hF0});
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();

    // Back-to-back: read held through DONE into IDLE.
    bus.line_address_i = 32'h0000_0100;
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 64'hC0 + 64'(k));
      tick();
    end
    gline = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    chk("b2b first resp", 256'(bus.line_resp_o), 256'h1);
    chk("b2b first line", bus.line_rdata_o, gline);
    drive(1'b1, 1'b0, 1'b0, 64'h0);
    tick();
    chk("b2b idle mem_read", 256'(bus.mem_read_o), 256'h0);
    chk("b2b idle resp", 256'(bus.line_resp_o), 256'h0);
    tick();
    chk("b2b second mem_read", 256'(bus.mem_read_o), 256'h1);
    chk("b2b line held", bus.line_rdata_o, gline);
    tick();
    chk("b2b line held stall", bus.line_rdata_o, gline);
    drive(1'b1, 1'b0, 1'b1, 64'h90);
    tick();
    chk("b2b beat0 lands", bus.line_rdata_o, {64'hC3, 64'hC2, 64'hC1, 64'h90});
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, 64'h90 + 64'(k));
      tick();
    end
    chk("b2b second resp", 256'(bus.line_resp_o), 256'h1);
    chk("b2b second line", bus.line_rdata_o, {64'h93, 64'h92, 64'h91, 64'h90});
    drive(1'b0, 1'b0, 1'b0, 64'h0);
    tick();
    chk("b2b final idle", 256'(bus.mem_read_o), 256'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
